// File: rtl/ar_ctrl_pkg.sv
// ar_ctrl_pkg: state, grant and AR source-select encodings shared by the AR access controller.
package ar_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MEM  = 2'd2,
    DONE = 2'd3
  } state_e;
  localparam logic FETCH   = 1'b0;
  localparam logic OPER    = 1'b1;
  localparam logic SEL_BUS = 1'b0;
  localparam logic SEL_IMM = 1'b1;
endpackage

// File: rtl/ar_access_ctrl_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter; a tie goes to the requester
// that did not win last time (req[0]=FETCH, req[1]=OPER).
module rr_arb2
  import ar_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastGnt,
  output logic       gnt,
  output logic       valid
);
  always_comb begin
    valid = |req;
    gnt   = (&req) ? ~lastGnt : (req[1] ? OPER : FETCH);
  end
endmodule

// File: rtl/ar_access_ctrl.sv
// ar_access_ctrl: arbitrates fetch/operand AR loads and sequences the following memory read.
// Optional macro AR_TIMEOUT_EN adds a WAIT_MAX-cycle MEM timeout reported on Err.
module ar_access_ctrl
  import ar_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic ReqFetch,
  input  logic ReqOper,
  input  logic MemRdy,
  output logic WEN,
  output logic selAR,
  output logic MemRd,
  output logic AckFetch,
  output logic AckOper,
  output logic Busy,
  output logic Err
);
  state_e state_q, state_d;
  logic   gnt_q, last_q, arb_gnt, arb_valid, tmo;

  if (2 ** CNT_W <= WAIT_MAX) begin : g_bad_cnt_w
    $error("CNT_W too narrow for WAIT_MAX");
  end

  rr_arb2 u_arb (
    .req    ({ReqOper, ReqFetch}),
    .lastGnt(last_q),
    .gnt    (arb_gnt),
    .valid  (arb_valid)
  );

`ifdef AR_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  assign tmo = state_q == MEM && !MemRdy && cnt_q == CNT_W'(WAIT_MAX);
  always_ff @(posedge Clk)
    cnt_q <= (!Rst_n || state_q == LOAD) ? '0 : (state_q == MEM) ? cnt_q + 1'b1 : cnt_q;
`else
  assign tmo = 1'b0;
`endif

  always_comb
    state_d = (state_q == IDLE) ? (arb_valid ? LOAD : IDLE) :
              (state_q == LOAD) ? MEM :
              (state_q == MEM)  ? ((MemRdy || tmo) ? DONE : MEM) : IDLE;

  // Outputs are decoded from the next state so each one is a flop aligned with its state.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= FETCH;
      last_q   <= OPER;
      WEN      <= 1'b0;
      selAR    <= 1'b0;
      MemRd    <= 1'b0;
      AckFetch <= 1'b0;
      AckOper  <= 1'b0;
      Busy     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (state_q == IDLE && arb_valid) gnt_q <= arb_gnt;
      if (state_q == DONE) last_q <= gnt_q;
      WEN      <= state_d == LOAD;
      selAR    <= (state_d == LOAD) ? ((arb_gnt == OPER) ? SEL_IMM : SEL_BUS) : 1'b0;
      MemRd    <= state_d == MEM;
      AckFetch <= state_d == DONE && gnt_q == FETCH;
      AckOper  <= state_d == DONE && gnt_q == OPER;
      Busy     <= state_d != IDLE;
      Err      <= tmo;
    end
  end
endmodule

// File: tb/tb_ar_access_ctrl.sv
// tb_ar_access_ctrl: directed bench with a transaction-level model checked every cycle,
// plus literal per-cycle expectations. Output vector: {WEN,selAR,MemRd,AckFetch,AckOper,Busy,Err}.
module tb_ar_access_ctrl;
  localparam int WAIT_MAX = 15;
`ifdef AR_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  logic Clk = 1'b0, Rst_n = 1'b0, ReqFetch = 1'b0, ReqOper = 1'b0, MemRdy = 1'b0;
  logic WEN, selAR, MemRd, AckFetch, AckOper, Busy, Err;
  logic [6:0] dv;
  int n_cmp = 0, n_bad = 0;
  bit started = 1'b0;

  ar_access_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReqFetch(ReqFetch), .ReqOper(ReqOper), .MemRdy(MemRdy),
    .WEN(WEN), .selAR(selAR), .MemRd(MemRd), .AckFetch(AckFetch), .AckOper(AckOper),
    .Busy(Busy), .Err(Err)
  );

  assign dv = {WEN, selAR, MemRd, AckFetch, AckOper, Busy, Err};
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // Transaction model: an access is granted, loads AR for one cycle, reads until MemRdy
  // (or the timeout budget), then acknowledges and leaves one idle cycle.
  bit act, loaded, fin, own, last_g;
  int waited;
  logic [6:0] ex;
  always @(posedge Clk) begin
    ex = '0;
    if (!Rst_n) begin
      act = 0; fin = 0; last_g = 1;
    end else if (fin) begin
      fin = 0; act = 0; last_g = own;
    end else if (!act) begin
      if (ReqFetch || ReqOper) begin
        own = (ReqFetch && ReqOper) ? !last_g : ReqOper;
        act = 1; loaded = 0; waited = 0;
        ex[6] = 1; ex[5] = own;
      end
    end else if (!loaded) begin
      loaded = 1; ex[4] = 1;
    end else if (MemRdy || (TMO && waited == WAIT_MAX)) begin
      fin = 1; ex[own ? 2 : 3] = 1; ex[0] = !MemRdy;
    end else begin
      waited++; ex[4] = 1;
    end
    ex[1] = act;
    started = 1'b1;
  end

  always @(negedge Clk) if (started) chk("model", dv, ex);

  task automatic step(input string name, input logic [6:0] exp);
    @(negedge Clk);
    chk(name, dv, exp);
  endtask

  task automatic do_reset();
    @(negedge Clk); Rst_n = 0;
    step("reset", 7'b0);
    Rst_n = 1;
  endtask

  logic [6:0] rr_tab [12] = '{7'b1000010, 7'b0010010, 7'b0001010, 7'b0,
                              7'b1100010, 7'b0010010, 7'b0000110, 7'b0,
                              7'b1000010, 7'b0010010, 7'b0001010, 7'b0};

  initial begin
    do_reset();
    // single fetch, memory ready immediately
    ReqFetch = 1; MemRdy = 1;
    step("t1_load", 7'b1000010); ReqFetch = 0;
    step("t1_mem", 7'b0010010);
    step("t1_ack", 7'b0001010);
    step("t1_idle", 7'b0); MemRdy = 0;
    // both requesting: FETCH, OPER, FETCH
    do_reset();
    ReqFetch = 1; ReqOper = 1; MemRdy = 1;
    for (int i = 0; i < 12; i++) begin
      step($sformatf("t2_rr%0d", i), rr_tab[i]);
      if (i == 10) begin ReqFetch = 0; ReqOper = 0; end
    end
    MemRdy = 0;
    // operand with five wait cycles
    ReqOper = 1;
    step("t3_load", 7'b1100010); ReqOper = 0;
    for (int i = 0; i < 6; i++) step($sformatf("t3_mem%0d", i), 7'b0010010);
    MemRdy = 1;
    step("t3_ack", 7'b0000110); MemRdy = 0;
    step("t3_idle", 7'b0);
    // memory never ready
    ReqFetch = 1;
    step("t4_load", 7'b1000010); ReqFetch = 0;
`ifdef AR_TIMEOUT_EN
    for (int i = 0; i < 16; i++) step($sformatf("t4_mem%0d", i), 7'b0010010);
    step("t4_tmo", 7'b0001011);
    step("t4_idle", 7'b0);
`else
    for (int i = 0; i < 100; i++) step($sformatf("t4_mem%0d", i), 7'b0010010);
    do_reset();
`endif
    // reset during MEM aborts without Ack, then a new operand access is served
    ReqOper = 1;
    step("t5_load", 7'b1100010); ReqOper = 0;
    step("t5_mem", 7'b0010010);
    Rst_n = 0;
    step("t5_abort", 7'b0); Rst_n = 1;
    step("t5_noack0", 7'b0);
    step("t5_noack1", 7'b0);
    ReqOper = 1; MemRdy = 1;
    step("t5_load2", 7'b1100010); ReqOper = 0;
    step("t5_mem2", 7'b0010010);
    step("t5_ack2", 7'b0000110);
    step("t5_idle2", 7'b0);
    // MemRdy in IDLE is ignored; one-cycle fetch pulse still completes
    step("t6_idle_rdy0", 7'b0);
    step("t6_idle_rdy1", 7'b0); MemRdy = 0; ReqFetch = 1;
    step("t6_load", 7'b1000010); ReqFetch = 0;
    step("t6_mem0", 7'b0010010); MemRdy = 1;
    step("t6_ack", 7'b0001010); MemRdy = 0;
    step("t6_idle", 7'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
